// File: rtl/traffic_phase_timer_pkg.sv
// Shared phase identifiers and power-on phase durations for the traffic phase timer.
package traffic_pkg;

    typedef enum int unsigned {
        PH_NS_GREEN  = 0,
        PH_NS_YELLOW = 1,
        PH_EW_GREEN  = 2,
        PH_EW_YELLOW = 3
    } phase_id_e;

    localparam int unsigned NUM_DEF = 4;
    localparam int unsigned DEF_DUR [NUM_DEF] = '{30, 3, 15, 3};

    // Default duration for any phase index; tables larger than four entries repeat the pattern.
    function automatic int unsigned def_dur(input int unsigned idx);
        return DEF_DUR[idx[1:0]];
    endfunction

endpackage

// File: rtl/traffic_phase_timer_if.sv
// Control/status bundle of the traffic phase timer.
interface traffic_phase_timer_if #(
    parameter int unsigned PH_W  = 2,
    parameter int unsigned CNT_W = 8
);

    logic             hold;
    logic             force_en;
    logic [PH_W-1:0]  force_phase;
    logic             dur_we;
    logic [PH_W-1:0]  dur_addr;
    logic [CNT_W-1:0] dur_wdata;
    logic [PH_W-1:0]  phase;
    logic [CNT_W-1:0] count;
    logic [11:0]      count_bcd;
    logic             tick;
    logic             phase_done;

    modport master (
        output hold, force_en, force_phase, dur_we, dur_addr, dur_wdata,
        input  phase, count, count_bcd, tick, phase_done
    );

    modport slave (
        input  hold, force_en, force_phase, dur_we, dur_addr, dur_wdata,
        output phase, count, count_bcd, tick, phase_done
    );

endinterface

// File: rtl/traffic_phase_timer_bin2bcd.sv
// 8-bit binary to three-digit BCD, combinational double-dabble.
module bin2bcd (
    input  logic [7:0]  bin,
    output logic [11:0] bcd
);

    logic [19:0] sr;

    // Shift-add-3: correct each BCD digit before every shift; hundreds never exceeds 2.
    always_comb begin
        sr = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sr[11:8] >= 4'd5) begin
                sr[11:8] = sr[11:8] + 4'd3;
            end
            if (sr[15:12] >= 4'd5) begin
                sr[15:12] = sr[15:12] + 4'd3;
            end
            sr = {sr[18:0], 1'b0};
        end
        bcd = sr[19:8];
    end

endmodule

// File: rtl/traffic_phase_timer.sv
// Cyclic phase sequencer: prescaled countdown per phase, hold, forced jumps, writable durations.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int unsigned NUM_PHASES = 4,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned TICK_DIV   = 10,
    parameter int unsigned PH_W       = 2
) (
    input logic                clk,
    input logic                rst,
    traffic_phase_timer_if.slave bus
);

    localparam int unsigned      PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(NUM_PHASES - 1);

    logic [PS_W-1:0]  pre_q, pre_n;
    logic [PH_W-1:0]  phase_q, phase_n, phase_nx;
    logic [CNT_W-1:0] count_q, count_n;
    logic             tick_q, tick_n;
    logic             done_q, done_n;
    logic [CNT_W-1:0] dur [NUM_PHASES];
    logic             force_ok;
    logic             tick_now;
    logic [7:0]       bin8;
    logic [11:0]      bcd;

    // Count loaded on phase entry; a stored zero still gives one tick.
    function automatic logic [CNT_W-1:0] load_of(input logic [CNT_W-1:0] d);
        return (d == '0) ? '0 : d - CNT_W'(1);
    endfunction

    // Next-state: force beats hold and tick; hold freezes everything else.
    always_comb begin
        pre_n    = pre_q;
        phase_n  = phase_q;
        count_n  = count_q;
        tick_n   = 1'b0;
        done_n   = 1'b0;
        force_ok = bus.force_en && (32'(bus.force_phase) < NUM_PHASES);
        tick_now = !bus.hold && (pre_q == PS_LAST);
        phase_nx = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        if (force_ok) begin
            phase_n = bus.force_phase;
            count_n = load_of(dur[bus.force_phase]);
            pre_n   = '0;
            done_n  = 1'b1;
        end else if (!bus.hold) begin
            if (tick_now) begin
                pre_n  = '0;
                tick_n = 1'b1;
                if (count_q != '0) begin
                    count_n = count_q - CNT_W'(1);
                end else begin
                    phase_n = phase_nx;
                    count_n = load_of(dur[phase_nx]);
                    done_n  = 1'b1;
                end
            end else begin
                pre_n = pre_q + PS_W'(1);
            end
        end
    end

    // Sequencer state and registered pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            phase_q <= PH_W'(PH_NS_GREEN);
            count_q <= load_of(CNT_W'(def_dur(0)));
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            pre_q   <= pre_n;
            phase_q <= phase_n;
            count_q <= count_n;
            tick_q  <= tick_n;
            done_q  <= done_n;
        end
    end

    // Duration table in flops; out-of-range writes are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_PHASES; i++) begin
                dur[i] <= CNT_W'(def_dur(i));
            end
        end else if (bus.dur_we && (32'(bus.dur_addr) < NUM_PHASES)) begin
            dur[bus.dur_addr] <= bus.dur_wdata;
        end
    end

    assign bin8 = 8'(count_q);

    bin2bcd u_bcd (
        .bin (bin8),
        .bcd (bcd)
    );

    assign bus.phase      = phase_q;
    assign bus.count      = count_q;
    assign bus.count_bcd  = bcd;
    assign bus.tick       = tick_q;
    assign bus.phase_done = done_q;

endmodule
